axils_regfile: RTL and testbench

AXILS_REGFILE -- requirements
Module: axils_regfile

---
 rtl/axil_pkg.sv | 23 ++
 rtl/axils_decode.sv | 30 +++
 rtl/axils_regfile.sv | 218 +++++++++++++++++++++
 tb/tb_axils_regfile.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register file.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   w_state_e / r_state_e   : write and read channel FSM states
//   NREG                    : address slots (7 R/W registers + 1 status word)
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int         NREG        = 8;
    localparam logic [2:0] STS_IDX     = 3'd7;

    typedef enum logic {
        W_COLLECT = 1'b0,
        W_RESP    = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axils_decode.sv
// Address decoder for the register window.
//   addr     : byte address from AW or AR channel
//   index    : word slot within the 32-byte window
//   mapped   : address lies inside BASE_ADDR .. BASE_ADDR+0x1F
//   writable : mapped and not the read-only status slot
import axil_pkg::*;

module axils_decode #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic [31:0] addr,
    output logic [2:0]  index,
    output logic        mapped,
    output logic        writable
);

    logic [31:0] offset;
    logic        unused_offset_lsbs;

    // Byte lanes within a word are irrelevant; only the word slot matters.
    assign unused_offset_lsbs = ^offset[1:0];

    always_comb begin
        offset   = addr - BASE_ADDR;
        mapped   = (offset[31:5] == 27'd0);
        index    = offset[4:2];
        writable = mapped && (offset[4:2] != STS_IDX);
    end

endmodule

// File: rtl/axils_regfile.sv
// AXI4-Lite slave: seven R/W registers plus a read-only status word.
//   ACLK, ARESETn          : clock, async active-low reset
//   AW*/W*/B*              : write address, data and response channels
//   AR*/R*                 : read address and data channels
//   STS_I                  : status word returned at offset 0x1C
//   REG_O                  : registers 0..6 concatenated, reg0 in [31:0]
// All channel outputs come straight from flops, so none depends
// combinationally on a VALID/READY input.
import axil_pkg::*;

module axils_regfile #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [31:0]            AWADDR,
    input  logic [2:0]             AWPROT,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [31:0]            WDATA,
    input  logic [3:0]             WSTRB,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic [1:0]             BRESP,
    output logic                   BVALID,
    input  logic                   BREADY,
    input  logic [31:0]            ARADDR,
    input  logic [2:0]             ARPROT,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [31:0]            RDATA,
    output logic [1:0]             RRESP,
    output logic                   RVALID,
    input  logic                   RREADY,
    input  logic [31:0]            STS_I,
    output logic [(NREG-1)*32-1:0] REG_O
);

    w_state_e    w_state_q, w_state_d;
    r_state_e    r_state_q, r_state_d;
    logic        aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
    logic [31:0] aw_addr_q, aw_addr_d, w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        awready_q, awready_d, wready_q, wready_d;
    logic        bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] regs_q [NREG-1], regs_d [NREG-1];

    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic [2:0]  wr_idx, rd_idx;
    logic        wr_mapped, wr_writable, rd_mapped, rd_writable;
    logic        unused_prot;

    assign unused_prot = ^{AWPROT, ARPROT, wr_mapped, rd_writable};

    assign aw_hs = awready_q & AWVALID;
    assign w_hs  = wready_q & WVALID;
    assign ar_hs = arready_q & ARVALID;

    // The write commits on the edge where the second of AW/W arrives, so the
    // live channel value is used for whichever half is not yet latched.
    assign wr_addr = aw_lat_q ? aw_addr_q : AWADDR;
    assign wr_data = w_lat_q  ? w_data_q  : WDATA;
    assign wr_strb = w_lat_q  ? w_strb_q  : WSTRB;

    axils_decode #(.BASE_ADDR(BASE_ADDR)) u_dec_wr (
        .addr(wr_addr), .index(wr_idx), .mapped(wr_mapped), .writable(wr_writable)
    );

    axils_decode #(.BASE_ADDR(BASE_ADDR)) u_dec_rd (
        .addr(ARADDR), .index(rd_idx), .mapped(rd_mapped), .writable(rd_writable)
    );

    always_comb begin
        w_state_d = w_state_q;
        aw_lat_d  = aw_lat_q;
        aw_addr_d = aw_addr_q;
        w_lat_d   = w_lat_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        case (w_state_q)
            W_COLLECT: begin
                if (aw_hs) begin
                    aw_lat_d  = 1'b1;
                    aw_addr_d = AWADDR;
                end
                if (w_hs) begin
                    w_lat_d  = 1'b1;
                    w_data_d = WDATA;
                    w_strb_d = WSTRB;
                end
                if ((aw_lat_q | aw_hs) && (w_lat_q | w_hs)) begin
                    if (wr_writable) begin
                        for (int r = 0; r < NREG - 1; r++) begin
                            if (wr_idx == r[2:0]) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (wr_strb[b]) regs_d[r][8*b +: 8] = wr_data[8*b +: 8];
                                end
                            end
                        end
                    end
                    bresp_d   = wr_writable ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    awready_d = !(aw_lat_q | aw_hs);
                    wready_d  = !(w_lat_q | w_hs);
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    aw_lat_d  = 1'b0;
                    w_lat_d   = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_COLLECT;
                end
            end
            default: w_state_d = W_COLLECT;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rresp_d   = rd_mapped ? RESP_OKAY : RESP_SLVERR;
                    rdata_d   = 32'h0;
                    if (rd_mapped && rd_idx == STS_IDX) rdata_d = STS_I;
                    for (int r = 0; r < NREG - 1; r++) begin
                        if (rd_mapped && rd_idx == r[2:0]) rdata_d = regs_q[r];
                    end
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_COLLECT;
            r_state_q <= R_IDLE;
            aw_lat_q  <= 1'b0;
            aw_addr_q <= 32'h0;
            w_lat_q   <= 1'b0;
            w_data_q  <= 32'h0;
            w_strb_q  <= 4'h0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= RESP_OKAY;
            for (int r = 0; r < NREG - 1; r++) regs_q[r] <= 32'h0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_lat_q  <= aw_lat_d;
            aw_addr_q <= aw_addr_d;
            w_lat_q   <= w_lat_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    always_comb begin
        REG_O = '0;
        for (int r = 0; r < NREG - 1; r++) REG_O[32*r +: 32] = regs_q[r];
    end

endmodule

// File: tb/tb_axils_regfile.sv
// Self-checking bench for axils_regfile: expected write responses and read
// data are queued when a transaction is issued and compared when the DUT
// completes the matching handshake.
module tb_axils_regfile;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic         ACLK = 1'b0;
    logic         ARESETn;
    logic [31:0]  AWADDR, WDATA, ARADDR, RDATA, STS_I;
    logic [2:0]   AWPROT, ARPROT;
    logic [3:0]   WSTRB;
    logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic         ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]   BRESP, RRESP;
    logic [223:0] REG_O;

    always #5 ACLK = ~ACLK;

    axils_regfile #(.BASE_ADDR(BASE)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .STS_I(STS_I), .REG_O(REG_O)
    );

    int          n_err = 0;
    int          n_chk = 0;
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    logic [31:0] mregs [7];
    logic [1:0]  b_exp;
    logic [33:0] r_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_wresp(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (off < 32 && off[4:2] != 3'd7) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [33:0] exp_read(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (off >= 32)          return {2'b10, 32'h0};
        if (off[4:2] == 3'd7)   return {2'b00, STS_I};
        return {2'b00, mregs[off[4:2]]};
    endfunction

    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) chk("b_queue_nonempty", bq.size(), 1);
                else begin
                    b_exp = bq.pop_front();
                    chk("bresp", {30'h0, BRESP}, {30'h0, b_exp});
                end
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) chk("r_queue_nonempty", rq.size(), 1);
                else begin
                    r_exp = rq.pop_front();
                    chk("rdata", RDATA, r_exp[31:0]);
                    chk("rresp", {30'h0, RRESP}, {30'h0, r_exp[33:32]});
                end
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 20 && (bq.size() != 0 || rq.size() != 0); i++) @(negedge ACLK);
        chk("drain_b", bq.size(), 0);
        chk("drain_r", rq.size(), 0);
    endtask

    // w_lead > 0: W offered that many cycles before AW; < 0: AW first.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input int stall);
        logic [1:0]  e;
        logic [31:0] off;
        bit          aw_done, w_done, aw_hs, w_hs;
        int          aw_start, w_start, cyc;
        e   = exp_wresp(addr);
        off = addr - BASE;
        bq.push_back(e);
        if (e == 2'b00)
            for (int b = 0; b < 4; b++)
                if (strb[b]) mregs[off[4:2]][8*b +: 8] = data[8*b +: 8];
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 0; w_done = 0; cyc = 0;
        @(posedge ACLK); #1;
        if (stall > 0) BREADY = 1'b0;
        while (!(aw_done && w_done) && cyc < 40) begin
            AWVALID = !aw_done && cyc >= aw_start;
            AWADDR  = addr;
            WVALID  = !w_done && cyc >= w_start;
            WDATA   = data;
            WSTRB   = strb;
            @(negedge ACLK);
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            cyc++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        chk("wr_accept", {30'h0, aw_done, w_done}, 32'h3);
        @(negedge ACLK);
        chk("bvalid_lat", {31'h0, BVALID}, 32'h1);
        for (int k = 0; k < stall; k++) begin
            chk("bvalid_hold", {31'h0, BVALID}, 32'h1);
            chk("bresp_hold", {30'h0, BRESP}, {30'h0, e});
            chk("awready_resp", {31'h0, AWREADY}, 32'h0);
            @(negedge ACLK);
        end
        if (stall > 0) begin
            @(posedge ACLK); #1;
            BREADY = 1'b1;
        end
        wait_drain();
    endtask

    task automatic do_read(input logic [31:0] addr);
        bit hs;
        int cyc;
        rq.push_back(exp_read(addr));
        hs = 0; cyc = 0;
        @(posedge ACLK); #1;
        while (!hs && cyc < 40) begin
            ARVALID = 1'b1;
            ARADDR  = addr;
            @(negedge ACLK);
            hs = ARREADY;
            @(posedge ACLK); #1;
            cyc++;
        end
        ARVALID = 1'b0;
        chk("rd_accept", {31'h0, hs}, 32'h1);
        @(negedge ACLK);
        chk("rvalid_lat", {31'h0, RVALID}, 32'h1);
        wait_drain();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_readys"}, {29'h0, AWREADY, WREADY, ARREADY}, 32'h0);
        chk({tag, "_valids"}, {30'h0, BVALID, RVALID}, 32'h0);
        chk({tag, "_resps"}, {28'h0, BRESP, RRESP}, 32'h0);
        chk({tag, "_rdata"}, RDATA, 32'h0);
        chk({tag, "_reg_o"}, {31'h0, (REG_O == 224'h0)}, 32'h1);
    endtask

    initial begin
        ARESETn = 1'b0;
        AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0;
        BREADY = 1'b1; ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 1'b1;
        STS_I = 32'h0000_00A5;
        for (int i = 0; i < 7; i++) mregs[i] = 32'h0;

        #23;
        chk_reset_outputs("rst");
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        chk("rdy_after_rst", {29'h0, AWREADY, WREADY, ARREADY}, 32'h7);

        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("reg1_deadbeef", REG_O[63:32], 32'hDEADBEEF);

        do_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0);
        do_write(32'h08, 32'h11223344, 4'b0101, 2, 0);
        chk("reg2_merge", REG_O[95:64], 32'hAA22CC44);
        do_read(32'h08);

        do_write(32'h0D, 32'h12345678, 4'hC, -3, 0);
        chk("reg3_hi_bytes", REG_O[127:96], 32'h1234_0000);
        do_read(32'h0C);

        do_write(32'h10, 32'hFFFFFFFF, 4'h0, 0, 0);
        do_read(32'h10);

        do_read(32'h1C);
        do_write(32'h1C, 32'h0, 4'hF, 0, 0);
        do_read(32'h1C);

        do_read(32'h40);
        do_read(32'h20);
        do_write(32'h40, 32'h1, 4'hF, 1, 5);

        do_write(32'h18, 32'hCAFEF00D, 4'hF, 0, 0);
        do_read(32'h18);

        // Write and read of reg0 hit the same edge: read returns old value.
        do_write(32'h00, 32'h3, 4'hF, 0, 0);
        bq.push_back(2'b00);
        rq.push_back({2'b00, 32'h3});
        mregs[0] = 32'h5;
        @(posedge ACLK); #1;
        AWVALID = 1; AWADDR = 0; WVALID = 1; WDATA = 32'h5; WSTRB = 4'hF;
        ARVALID = 1; ARADDR = 0;
        @(negedge ACLK);
        chk("same_cycle_ready", {29'h0, AWREADY, WREADY, ARREADY}, 32'h7);
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        wait_drain();
        do_read(32'h00);

        // Reset with only AW latched.
        @(posedge ACLK); #1;
        AWVALID = 1; AWADDR = 32'h04;
        @(negedge ACLK);
        chk("aw_only_ready", {31'h0, AWREADY}, 32'h1);
        @(posedge ACLK); #1;
        AWVALID = 0;
        @(negedge ACLK);
        chk("aw_latched", {30'h0, AWREADY, WREADY}, 32'h1);
        #2;
        ARESETn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        for (int i = 0; i < 7; i++) mregs[i] = 32'h0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        chk("rdy_after_midrst", {29'h0, AWREADY, WREADY, ARREADY}, 32'h7);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            chk("no_bvalid_after_rst", {31'h0, BVALID}, 32'h0);
        end
        do_read(32'h04);

        for (int i = 0; i < 7; i++) chk("final_reg", REG_O[32*i +: 32], mregs[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
